// File: rtl/div_by_five.sv
`default_nettype none
// ============================================================================
//  Module      : div_by_five
//  Description : Serial divisibility-by-5 detector. Accepts one bit per
//                valid-qualified clock, MSB first, tracks the running value
//                modulo 5 and flags when the accumulated number is a
//                multiple of 5. Also exposes the remainder and a saturating
//                accepted-bit count.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_by_five #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,       // synchronous, active-high despite the name
    input  logic             din,
    input  logic             din_valid,
    output logic             div_by_5,
    output logic [2:0]       remainder,
    output logic [CNT_W-1:0] bit_count
);

    // Remainder states; the encoding equals the remainder value so the
    // state register drives the remainder output directly.
    typedef enum logic [2:0] {
        c_r0 = 3'd0,
        c_r1 = 3'd1,
        c_r2 = 3'd2,
        c_r3 = 3'd3,
        c_r4 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_started;
    logic             w_started_nxt;
    logic [CNT_W-1:0] r_bit_count;
    logic [CNT_W-1:0] w_bit_count_nxt;
    logic             r_div_by_5;
    logic             w_div_by_5_nxt;

    // Next-state logic: shift in one bit, r' = (2r + din) mod 5.
    always_comb begin
        w_state_nxt     = r_state;
        w_started_nxt   = r_started;
        w_bit_count_nxt = r_bit_count;

        case (r_state)
            c_r0, c_r1, c_r2, c_r3, c_r4: begin
                if (din_valid) begin
                    w_started_nxt = 1'b1;
                    if (r_bit_count != C_CNT_MAX) begin
                        w_bit_count_nxt = r_bit_count + C_CNT_ONE;
                    end
                    case (r_state)
                        c_r0:    w_state_nxt = din ? c_r1 : c_r0;
                        c_r1:    w_state_nxt = din ? c_r3 : c_r2;
                        c_r2:    w_state_nxt = din ? c_r0 : c_r4;
                        c_r3:    w_state_nxt = din ? c_r2 : c_r1;
                        c_r4:    w_state_nxt = din ? c_r4 : c_r3;
                        default: w_state_nxt = c_r0;
                    endcase
                end
            end
            default: begin
                // Corrupted encoding: fall back to R0 and withhold the
                // divisible flag until a fresh bit is accepted.
                w_state_nxt   = c_r0;
                w_started_nxt = 1'b0;
            end
        endcase

        w_div_by_5_nxt = w_started_nxt && (w_state_nxt == c_r0);
    end

    // State, flag and counter registers; reset wins over an incoming bit.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= c_r0;
            r_started   <= 1'b0;
            r_bit_count <= '0;
            r_div_by_5  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_started   <= w_started_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_div_by_5  <= w_div_by_5_nxt;
        end
    end

    assign div_by_5  = r_div_by_5;
    assign remainder = r_state;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_div_by_five.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_by_five
//  Description : Scoreboard bench for div_by_five. The driver pushes the
//                expected outputs for each edge computed from the running
//                value modulo 5; a monitor pops and compares after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_by_five;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             din;
    logic             din_valid;
    logic             div_by_5;
    logic [2:0]       remainder;
    logic [CNT_W-1:0] bit_count;

    div_by_five #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_valid (din_valid),
        .div_by_5  (div_by_5),
        .remainder (remainder),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       div;
        logic [2:0] rem;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_edge = 0;

    // Reference model: the number seen so far, kept only modulo 5.
    int m_rem     = 0;
    bit m_started = 1'b0;
    int m_cnt     = 0;

    task automatic drive(input bit rst, input bit v, input bit d);
        exp_t e;
        @(negedge clk);
        rstn      = rst;
        din_valid = v;
        din       = d;
        if (rst) begin
            m_rem     = 0;
            m_started = 1'b0;
            m_cnt     = 0;
        end else if (v) begin
            m_rem     = (m_rem * 2 + int'(d)) % 5;
            m_started = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        e.div = m_started && (m_rem == 0);
        e.rem = 3'(m_rem);
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input int n, input logic [31:0] bits);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i]);
    endtask

    // Monitor: after every edge, compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_edge++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (div_by_5 !== e.div) begin
                n_bad++;
                $display("FAIL div_by_5 edge %0d: got %b expected %b", n_edge, div_by_5, e.div);
            end
            n_cmp++;
            if (remainder !== e.rem) begin
                n_bad++;
                $display("FAIL remainder edge %0d: got %0d expected %0d", n_edge, remainder, e.rem);
            end
            n_cmp++;
            if (int'(bit_count) !== e.cnt) begin
                n_bad++;
                $display("FAIL bit_count edge %0d: got %0d expected %0d", n_edge, bit_count, e.cnt);
            end
        end
    end

    initial begin
        rstn      = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);

        // 20 = 10100
        send_bits(5, 32'b10100);

        // 25 = 11001
        drive(1'b1, 1'b0, 1'b0);
        send_bits(5, 32'b11001);

        // Empty stream not divisible, then a single zero is
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        send_bits(1, 32'b0);

        // 2, hold with din toggling, then 5
        drive(1'b1, 1'b0, 1'b0);
        send_bits(2, 32'b10);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'(i % 2));
        send_bits(1, 32'b1);

        // 7, reset with a valid 1 presented, then 101
        drive(1'b1, 1'b0, 1'b0);
        send_bits(3, 32'b111);
        drive(1'b1, 1'b1, 1'b1);
        send_bits(3, 32'b101);

        // Counter saturation with a long run of zeros
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b0);

        // Randomized stream with gaps and occasional resets
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0);

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
